// File: rtl/gpio_irq.sv
// rtl/gpio_irq.sv - GPIO peripheral with input synchronisers, atomic output updates and edge interrupts
// Sits on the picorv32 native bus. Each access takes one wait state, then mem_ready pulses for one cycle.
module gpio_irq #(
  parameter int          NR_GPIOS    = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_OE    = 32'h0
) (
  input  logic                clk,
  input  logic                reset_,
  input  logic                mem_sel,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic                mem_wr,
  input  logic [11:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  output logic [31:0]         mem_rdata,
  output logic [NR_GPIOS-1:0] gpio_oe,
  output logic [NR_GPIOS-1:0] gpio_do,
  input  logic [NR_GPIOS-1:0] gpio_di,
  output logic                irq
);

  localparam logic [9:0] A_DATA_OUT   = 10'h000;
  localparam logic [9:0] A_OE         = 10'h001;
  localparam logic [9:0] A_DATA_IN    = 10'h002;
  localparam logic [9:0] A_OUT_SET    = 10'h003;
  localparam logic [9:0] A_OUT_CLR    = 10'h004;
  localparam logic [9:0] A_OUT_TGL    = 10'h005;
  localparam logic [9:0] A_RISE_EN    = 10'h006;
  localparam logic [9:0] A_FALL_EN    = 10'h007;
  localparam logic [9:0] A_IRQ_STATUS = 10'h008;
  localparam logic [9:0] A_INFO       = 10'h009;

  localparam logic [31:0] INFO_WORD = {16'h0002, 4'h0, SYNC_STAGES[3:0], NR_GPIOS[7:0]};

  logic [NR_GPIOS-1:0] data_out, oe, rise_en, fall_en, irq_status;
  logic [NR_GPIOS-1:0] sync_q [SYNC_STAGES];
  logic [NR_GPIOS-1:0] di_sync, di_prev, rise, fall, clr, wd;
  logic [9:0]          reg_idx;
  logic                accept, wr_en;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign unused_bits = ^{mem_addr[1:0], mem_wdata};

  // No back-to-back acceptance: the ready cycle itself can never accept.
  assign accept  = mem_valid & mem_sel & ~mem_ready;
  assign wr_en   = accept & mem_wr;
  assign reg_idx = mem_addr[11:2];
  assign wd      = mem_wdata[NR_GPIOS-1:0];

  assign gpio_do = data_out;
  assign gpio_oe = oe;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      di_prev <= '0;
    end else begin
      sync_q[0] <= gpio_di;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      di_prev <= di_sync;
    end
  end

  assign di_sync = sync_q[SYNC_STAGES-1];
  assign rise    = di_sync & ~di_prev;
  assign fall    = ~di_sync & di_prev;
  assign clr     = (wr_en && reg_idx == A_IRQ_STATUS) ? wd : '0;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      data_out <= RESET_OUT[NR_GPIOS-1:0];
      oe       <= RESET_OE[NR_GPIOS-1:0];
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        A_DATA_OUT: data_out <= wd;
        A_OE:       oe       <= wd;
        A_OUT_SET:  data_out <= data_out | wd;
        A_OUT_CLR:  data_out <= data_out & ~wd;
        A_OUT_TGL:  data_out <= data_out ^ wd;
        A_RISE_EN:  rise_en  <= wd;
        A_FALL_EN:  fall_en  <= wd;
        default:    ;
      endcase
    end
  end

  // Newly detected edges are ORed in after the clear, so set wins.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) irq_status <= '0;
    else         irq_status <= (irq_status & ~clr) | (rise & rise_en) | (fall & fall_en);
  end

  assign irq = |irq_status;

  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      A_DATA_OUT:   rd_mux = 32'(data_out);
      A_OE:         rd_mux = 32'(oe);
      A_DATA_IN:    rd_mux = 32'(di_sync);
      A_RISE_EN:    rd_mux = 32'(rise_en);
      A_FALL_EN:    rd_mux = 32'(fall_en);
      A_IRQ_STATUS: rd_mux = 32'(irq_status);
      A_INFO:       rd_mux = INFO_WORD;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= accept;
      mem_rdata <= accept ? rd_mux : 32'h0;
    end
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
Parametrised successor to the SoC GPIO peripheral. Adds:
- Per-pin input synchronisers.
- Atomic set/clear/toggle of outputs.
- Rise/fall edge detection with maskable, write-1-to-clear interrupt status and a level irq output.

It sits on the picorv32 native memory bus behind the SoC address decoder, at the 4 KB window 0xF000_0xxx. Its irq output feeds one bit of the CPU irq vector.

Parameters:
- NR_GPIOS, 8, number of pins, 1..32; register bits above NR_GPIOS-1 read 0 and ignore writes.
- SYNC_STAGES, 2, input synchroniser depth, 2..4.
- RESET_OUT, 0, reset value of DATA_OUT (NR_GPIOS bits).
- RESET_OE, 0, reset value of OE (NR_GPIOS bits).

Ports:
- clk  input  1  system clock.
- reset_  input  1  asynchronous active-low reset.
- mem_sel  input  1  address decoder select for this block.
- mem_valid  input  1  CPU bus request valid.
- mem_ready  output  1  access complete, one-cycle pulse.
- mem_wr  input  1  1 = write (any mem_wstrb bit set), 0 = read.
- mem_addr  input  12  byte offset in window; [11:2] selects register, [1:0] ignored.
- mem_wdata  input  32  write data; always a full-word write.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- gpio_oe  output  NR_GPIOS  output enable per pin.
- gpio_do  output  NR_GPIOS  output data per pin.
- gpio_di  input  NR_GPIOS  asynchronous pin inputs.
- irq  output  1  level interrupt, OR of IRQ_STATUS.

Behaviour:

Reset (async assert, sync release):
- mem_ready=0, mem_rdata=0.
- DATA_OUT=RESET_OUT, OE=RESET_OE.
- Sync chain, di_prev, RISE_EN, FALL_EN and IRQ_STATUS all 0; irq=0.
- gpio_do=DATA_OUT and gpio_oe=OE, driven directly from registers.

Bus handshake:
- Access accepted in cycle A when mem_valid & mem_sel & !mem_ready.
- At the end of cycle A: the register write commits, mem_rdata is registered, and mem_ready rises.
- mem_ready is high exactly one cycle, then forced low for one cycle even if valid stays high (no back-to-back acceptance).
- Latency: 1 wait state.
- mem_rdata = 0 whenever mem_ready=0.
- Reset asserted mid-access drops mem_ready immediately; no write is committed.

Register map (byte offset):
- 0x00 DATA_OUT, RW.
- 0x04 OE, RW.
- 0x08 DATA_IN, RO; synchronised input.
- 0x0C OUT_SET, WO: DATA_OUT |= wdata.
- 0x10 OUT_CLR, WO: DATA_OUT &= ~wdata.
- 0x14 OUT_TGL, WO: DATA_OUT ^= wdata.
- 0x18 RISE_EN, RW.
- 0x1C FALL_EN, RW.
- 0x20 IRQ_STATUS, read; writing 1 clears the bit.
- 0x24 INFO, RO: [7:0]=NR_GPIOS, [11:8]=SYNC_STAGES, [31:16]=16'h0002.
- Write-only registers read 0; unmapped offsets read 0 and ignore writes.

Input path:
- SYNC_STAGES-deep flop chain per pin; di_sync is the last stage.
- di_prev <= di_sync every cycle.
- rise = di_sync & ~di_prev; fall = ~di_sync & di_prev.
- A change on gpio_di before edge 1 appears in DATA_IN after edge SYNC_STAGES.

Status and irq:
- Each cycle: IRQ_STATUS <= (IRQ_STATUS & ~clr) | (rise & RISE_EN) | (fall & FALL_EN). clr is wdata on a committed write to 0x20, else 0.
- Set wins over a simultaneous W1C clear.
- Edge-to-status latency is SYNC_STAGES+1 edges.
- irq = |IRQ_STATUS, combinational from the register.
- Enables gate setting only; clearing an enable leaves pending status intact.
- Glitches shorter than one clock may be missed; this is not an error.

Test Plan:
1. Reset with RESET_OUT=8'hA5, RESET_OE=8'h0F -> gpio_do=A5, gpio_oe=0F, irq=0; read 0x24 returns 0x0002_0208.
2. Write 0x00=0x3C; OUT_SET 0x03; OUT_CLR 0x0C; OUT_TGL 0xF0 -> gpio_do 3C, 3F, 33, C3. Each access has mem_ready high for exactly 1 cycle, 1 cycle after valid. Reading 0x0C returns 0.
3. RISE_EN=0x01; drive gpio_di[0] 0->1 -> DATA_IN bit0=1 after 2 edges, IRQ_STATUS=0x01 and irq=1 after 3 edges. A falling edge with FALL_EN=0 leaves status unchanged.
4. Pending status 0x01; write 0x20=0x01 in the same cycle a new rise on pin 0 is detected -> status stays 0x01 and irq stays 1. A later write of 0x01 with no edge -> status 0, irq 0.
5. Hold mem_valid high continuously to 0x08 -> mem_ready pattern 0,1,0,1. An access to offset 0x80 reads 0 and a write there changes no register.
6. Assert reset_ low in the cycle mem_ready would rise on a write to 0x00=0xFF -> mem_ready stays 0 and gpio_do returns to RESET_OUT.
